// File: rtl/gradient_orientation_histogram.sv
// rtl/gradient_orientation_histogram.sv - 8-bin gradient orientation histogram over a keypoint window
// Scans the window in raster order, reads both gradient BRAMs, bins |gx|+|gy| by octant, then finds the peak.
module gradient_orientation_histogram #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int BIT_DEPTH = 8,
  parameter int RADIUS    = 4,
  parameter int BIN_W     = BIT_DEPTH + 2 + $clog2((2*RADIUS+1)*(2*RADIUS+1)+1)
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [$clog2(WIDTH)-1:0]          kp_x,
  input  logic [$clog2(HEIGHT)-1:0]         kp_y,
  input  logic                              start_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   grad_read_addr,
  output logic                              grad_read_valid,
  input  logic [BIT_DEPTH:0]                x_grad_in,
  input  logic [BIT_DEPTH:0]                y_grad_in,
  output logic                              busy,
  output logic [8*BIN_W-1:0]                hist_bins,
  output logic [2:0]                        peak_bin,
  output logic [BIN_W-1:0]                  peak_mag,
  output logic                              hist_done
);

  localparam int P   = (2*RADIUS+1)*(2*RADIUS+1);
  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int AW  = $clog2(WIDTH*HEIGHT);
  localparam int PCW = $clog2(P+1);
  localparam int DW  = $clog2(2*RADIUS+1);
  localparam int CW  = ((XW > YW) ? XW : YW) + $clog2(RADIUS+1) + 2;

  localparam logic signed [CW-1:0] R_S  = CW'(RADIUS);
  localparam logic signed [CW-1:0] W_S  = CW'(WIDTH);
  localparam logic signed [CW-1:0] H_S  = CW'(HEIGHT);
  localparam logic signed [CW-1:0] ZERO = '0;
  localparam logic signed [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, PEAK, DONE} state_t;
  state_t state, state_next;

  logic [XW-1:0]          kp_lx;
  logic signed [CW-1:0]   x_pos, y_pos;
  logic [DW-1:0]          dx_cnt;
  logic [PCW-1:0]         pos_cnt;
  logic                   drain_cnt;
  logic [1:0]             vpipe;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_in) state_next = SCAN;
      SCAN:  if (pos_cnt == PCW'(P)) state_next = DRAIN;
      DRAIN: if (drain_cnt) state_next = PEAK;
      PEAK:  state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next window position; the first one comes straight from the kp inputs on the accept cycle.
  logic signed [CW-1:0] nx, ny;
  logic [DW-1:0]        ndx;
  logic                 in_b, issue;
  logic [AW-1:0]        next_addr;

  always_comb begin
    nx  = x_pos + ONE;
    ny  = y_pos;
    ndx = dx_cnt + DW'(1);
    if (state == IDLE) begin
      nx  = CW'(kp_x) - R_S;
      ny  = CW'(kp_y) - R_S;
      ndx = '0;
    end else if (dx_cnt == DW'(2*RADIUS)) begin
      nx  = CW'(kp_lx) - R_S;
      ny  = y_pos + ONE;
      ndx = '0;
    end
    in_b      = (nx >= ZERO) && (nx < W_S) && (ny >= ZERO) && (ny < H_S);
    next_addr = AW'(nx) + AW'(ny) * AW'(WIDTH);
    issue     = ((state == IDLE) && start_in) || ((state == SCAN) && (pos_cnt != PCW'(P)));
  end

  logic              gx_neg, gy_neg, gx_z, gy_z, upd;
  logic [BIT_DEPTH:0]   ax, ay;
  logic [BIT_DEPTH+1:0] mag;
  logic [2:0]        sel;

  always_comb begin
    gx_neg = x_grad_in[BIT_DEPTH];
    gy_neg = y_grad_in[BIT_DEPTH];
    gx_z   = (x_grad_in == '0);
    gy_z   = (y_grad_in == '0);
    ax     = gx_neg ? (~x_grad_in + 1'b1) : x_grad_in;
    ay     = gy_neg ? (~y_grad_in + 1'b1) : y_grad_in;
    mag    = {1'b0, ax} + {1'b0, ay};
    upd    = 1'b1;
    sel    = 3'd0;
    if (!gx_neg && !gx_z && !gy_neg)       sel = (ay < ax) ? 3'd0 : 3'd1;
    else if ((gx_neg || gx_z) && !gy_neg && !gy_z) sel = (ax < ay) ? 3'd2 : 3'd3;
    else if (gx_neg && (gy_neg || gy_z))   sel = (ay < ax) ? 3'd4 : 3'd5;
    else if (!gx_neg && gy_neg)            sel = (ax < ay) ? 3'd6 : 3'd7;
    else                                   upd = 1'b0;
  end

  // Strictly-greater compare keeps the lowest index on ties.
  logic [2:0]       pk_b;
  logic [BIN_W-1:0] pk_v;

  always_comb begin
    pk_b = 3'd0;
    pk_v = hist_bins[0 +: BIN_W];
    for (int b = 1; b < 8; b++) begin
      if (hist_bins[b*BIN_W +: BIN_W] > pk_v) begin
        pk_v = hist_bins[b*BIN_W +: BIN_W];
        pk_b = 3'(b);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      kp_lx           <= '0;
      x_pos           <= '0;
      y_pos           <= '0;
      dx_cnt          <= '0;
      pos_cnt         <= '0;
      drain_cnt       <= 1'b0;
      vpipe           <= '0;
      grad_read_addr  <= '0;
      grad_read_valid <= 1'b0;
      busy            <= 1'b0;
      hist_bins       <= '0;
      peak_bin        <= '0;
      peak_mag        <= '0;
      hist_done       <= 1'b0;
    end else begin
      vpipe           <= {vpipe[0], grad_read_valid};
      hist_done       <= (state == PEAK);
      drain_cnt       <= (state == DRAIN) && !drain_cnt;
      grad_read_valid <= 1'b0;
      case (state)
        IDLE: if (start_in) begin
          kp_lx     <= kp_x;
          hist_bins <= '0;
          peak_bin  <= '0;
          peak_mag  <= '0;
          busy      <= 1'b1;
          pos_cnt   <= PCW'(1);
        end
        SCAN: if (pos_cnt != PCW'(P)) pos_cnt <= pos_cnt + PCW'(1);
        PEAK: begin
          peak_bin <= pk_b;
          peak_mag <= pk_v;
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
      if (issue) begin
        x_pos           <= nx;
        y_pos           <= ny;
        dx_cnt          <= ndx;
        grad_read_valid <= in_b;
        if (in_b) grad_read_addr <= next_addr;
      end
      if (vpipe[1] && upd)
        hist_bins[sel*BIN_W +: BIN_W] <= hist_bins[sel*BIN_W +: BIN_W] + BIN_W'(mag);
    end
  end

endmodule

// File: tb/tb_gradient_orientation_histogram.sv
// tb/tb_gradient_orientation_histogram.sv - directed checks for gradient_orientation_histogram
module tb_gradient_orientation_histogram;
  localparam int BW = 17;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [5:0]        kp_x, kp_y;
  logic              start_in;
  logic [11:0]       grad_read_addr;
  logic              grad_read_valid;
  logic [8:0]        x_grad_in, y_grad_in;
  logic              busy;
  logic [8*BW-1:0]   hist_bins;
  logic [2:0]        peak_bin;
  logic [BW-1:0]     peak_mag;
  logic              hist_done;

  always #5 clk_in = ~clk_in;

  gradient_orientation_histogram dut (
    .clk_in(clk_in), .rst_in(rst_in), .kp_x(kp_x), .kp_y(kp_y), .start_in(start_in),
    .grad_read_addr(grad_read_addr), .grad_read_valid(grad_read_valid),
    .x_grad_in(x_grad_in), .y_grad_in(y_grad_in), .busy(busy), .hist_bins(hist_bins),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .hist_done(hist_done)
  );

  logic [8:0]  gx_mem [4096];
  logic [8:0]  gy_mem [4096];
  logic [11:0] p1 = '0;

  // Two-cycle BRAM pair: address registered, then data registered.
  always @(posedge clk_in) begin
    p1        <= grad_read_addr;
    x_grad_in <= gx_mem[p1];
    y_grad_in <= gy_mem[p1];
  end

  int n_checks = 0, n_fail = 0;
  int reads = 0, bad = 0, win_x = 0, win_y = 0;

  always @(negedge clk_in) begin
    if (grad_read_valid) begin
      reads++;
      if ((int'(grad_read_addr) % 64) > win_x + 4 || (int'(grad_read_addr) % 64) < win_x - 4 ||
          (int'(grad_read_addr) / 64) > win_y + 4 || (int'(grad_read_addr) / 64) < win_y - 4)
        bad++;
    end
  end

  task automatic check(input string tag, input logic [8*BW-1:0] got, input logic [8*BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int gx, input int gy);
    for (int a = 0; a < 4096; a++) begin
      gx_mem[a] = 9'(gx);
      gy_mem[a] = 9'(gy);
    end
  endtask

  function automatic logic [8*BW-1:0] one_bin(input int b, input int v);
    logic [8*BW-1:0] r;
    r = '0;
    if (b >= 0) r[b*BW +: BW] = BW'(v);
    return r;
  endfunction

  task automatic run(input int kx, input int ky, input int pulse_cyc, input int rst_cyc,
                     input bit start_at_done, output int done_cyc);
    reads = 0; bad = 0; win_x = kx; win_y = ky;
    done_cyc = -1;
    @(negedge clk_in);
    kp_x = 6'(kx); kp_y = 6'(ky); start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0; kp_x = 6'(kx + 17); kp_y = 6'(ky + 9);
    for (int c = 1; c < 200; c++) begin
      if (c == 1) check("busy_c1", busy, 1);
      start_in = (c == pulse_cyc);
      if (c == pulse_cyc) begin kp_x = 0; kp_y = 0; end
      if (c == rst_cyc) begin
        rst_in = 1'b0;
        #1;
        check("rst_bins", hist_bins, 0);
        check("rst_peak_bin", peak_bin, 0);
        check("rst_peak_mag", peak_mag, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", grad_read_valid, 0);
        check("rst_addr", grad_read_addr, 0);
        check("rst_done", hist_done, 0);
        done_cyc = -2;
        break;
      end
      if (hist_done) begin
        done_cyc = c;
        start_in = start_at_done;
        @(negedge clk_in);
        start_in = 1'b0;
        check("busy_after_done", busy, 0);
        break;
      end
      @(negedge clk_in);
    end
    start_in = 1'b0;
  endtask

  int d;
  int oct_gx  [9] = '{5, 5, 0, -5, -256, -5, 0, 5, 0};
  int oct_gy  [9] = '{0, 5, 5, 5, 0, -5, -5, -5, 0};
  int oct_bin [9] = '{0, 1, 2, 3, 4, 5, 6, 7, -1};
  int oct_mag [9] = '{5, 10, 5, 10, 256, 10, 5, 10, 0};

  initial begin
    rst_in = 1'b0; start_in = 1'b0; kp_x = '0; kp_y = '0;
    fill(0, 0);
    repeat (3) @(negedge clk_in);
    check("reset_bins", hist_bins, 0);
    check("reset_peak_bin", peak_bin, 0);
    check("reset_peak_mag", peak_mag, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", grad_read_valid, 0);
    check("reset_done", hist_done, 0);
    rst_in = 1'b1;

    fill(10, 0);
    run(32, 32, 0, 0, 0, d);
    check("uni_done_cyc", 32'(d), 85);
    check("uni_reads", 32'(reads), 81);
    check("uni_bad_addr", 32'(bad), 0);
    check("uni_bins", hist_bins, one_bin(0, 810));
    check("uni_peak_bin", peak_bin, 0);
    check("uni_peak_mag", peak_mag, 810);

    fill(0, 3);
    run(0, 0, 0, 0, 1, d);
    check("corner_done_cyc", 32'(d), 85);
    check("corner_reads", 32'(reads), 25);
    check("corner_bad_addr", 32'(bad), 0);
    check("corner_bins", hist_bins, one_bin(2, 75));
    check("corner_peak_bin", peak_bin, 2);
    check("corner_peak_mag", peak_mag, 75);

    for (int i = 0; i < 9; i++) begin
      fill(0, 0);
      gx_mem[2080] = 9'(oct_gx[i]);
      gy_mem[2080] = 9'(oct_gy[i]);
      run(32, 32, 0, 0, 0, d);
      check($sformatf("octant_%0d_bins", i), hist_bins, one_bin(oct_bin[i], oct_mag[i]));
    end

    fill(0, 0);
    for (int i = 0; i < 4; i++) begin
      gx_mem[2080 + i] = 9'(-5);  gy_mem[2080 + i] = 9'(5);
      gx_mem[2144 + i] = 9'(0);   gy_mem[2144 + i] = 9'(-10);
    end
    gx_mem[2208] = 9'(5);
    run(32, 32, 0, 0, 0, d);
    check("tie_bins", hist_bins, one_bin(3, 40) | one_bin(6, 40) | one_bin(0, 5));
    check("tie_peak_bin", peak_bin, 3);
    check("tie_peak_mag", peak_mag, 40);

    fill(0, 0);
    run(32, 32, 0, 0, 0, d);
    check("zero_bins", hist_bins, 0);
    check("zero_peak_bin", peak_bin, 0);
    check("zero_peak_mag", peak_mag, 0);

    fill(10, 0);
    run(32, 32, 20, 0, 0, d);
    check("pulse_done_cyc", 32'(d), 85);
    check("pulse_reads", 32'(reads), 81);
    check("pulse_bins", hist_bins, one_bin(0, 810));

    fill(0, 7);
    run(32, 32, 0, 30, 0, d);
    check("rst_run_aborted", 32'(d), 32'(-2));
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    fill(10, 0);
    run(32, 32, 0, 0, 0, d);
    check("post_rst_done_cyc", 32'(d), 85);
    check("post_rst_bins", hist_bins, one_bin(0, 810));
    check("post_rst_peak_mag", peak_mag, 810);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
